match_filter_param: RTL and testbench
=====================================

Name: match_filter_param

Overview:
Parametrised complex correlator. It is the successor to the fixed 16-tap match filter in the inband receive path.
- Correlates the complex receive stream against a programmable ±1/±j sequence of up to TAPS coefficients.
- Computes a max+min/2 magnitude estimate and compares it to a threshold.
- Adds match holdoff, overrun detection and a magnitude output.
- Sits after the RX decimator; configured through the inband control channel (cdata/caddr/cwrite).

Parameters:
DW, 16, significant input sample width (sign bit = bit DW-1)
TAPS, 64, delay-line depth / max correlation length; multiple of PAR
PAR, 8, taps summed per clock in ACCUM
ACCW, 24, accumulator and magnitude width; must be >= DW+log2(TAPS)+1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
r_input  in  16  real sample; bits [DW-1:0] used
i_input  in  16  imaginary sample; bits [DW-1:0] used
rxstrobe  in  1  one-cycle sample-valid pulse
cdata  in  32  configuration write data
caddr  in  8  configuration register address
cwrite  in  1  configuration write strobe
valid  out  1  one-cycle pulse per processed sample
match  out  1  threshold crossing; qualified by valid
mag  out  ACCW  magnitude of last correlation; held until next valid
overrun  out  1  sticky sample-drop flag

Behaviour:
- Reset clears:
  - all outputs: valid=0, match=0, mag=0, overrun=0
  - delay line, coefficients, pending register, holdoff counter
  - configuration: threshold=0, len=TAPS, holdoff=0
  - FSM -> IDLE
- Config map (write-only, applied on the cycle after cwrite):
  - addr 0: threshold <= cdata[ACCW-1:0] (unsigned)
  - addr 1: len <= cdata[7:0] (active taps; 0 or >TAPS clamps to TAPS); holdoff <= cdata[31:16]
  - addr 2+k: coefficients 16k..16k+15, 2 bits each; coefficient 16k+m = cdata[2m+1:2m]
  - other addresses ignored
- Coefficient code applied to tap x=(r,i):
  - 00 -> (r, i)
  - 01 -> (-i, r)
  - 10 -> (i, -r)
  - 11 -> (-r, -i)
- Tap 0 = newest sample; coefficient k applies to tap k; taps k>=len contribute 0.
- Samples are sign-extended to ACCW before any arithmetic.
- Sample intake:
  - rxstrobe loads a one-deep pending register.
  - rxstrobe while pending is full: newest overwrites pending; overrun <= 1 (sticky until reset).
  - Config writes have no effect on sample intake.
- FSM:
  - IDLE: if pending full, shift pending into delay line, clear pending, zero accumulators -> ACCUM.
  - ACCUM: add PAR taps per cycle, beats b=0..N-1, N=ceil(len/PAR); after beat N-1 -> MAG.
  - MAG: mag <= max(|re|,|im|) + (min(|re|,|im|)>>1) -> CMP.
  - CMP: valid=1 for one cycle; match = (mag > threshold) && holdoff_cnt==0 -> IDLE.
- Latency: shift at cycle 0, ACCUM cycles 1..N, MAG N+1, valid at N+2.
  - Minimum strobe spacing without overrun: N+3 cycles.
- Holdoff:
  - On match, holdoff_cnt <= holdoff.
  - Each subsequent valid with holdoff_cnt>0 decrements it and forces match=0.
- Absolute value of the most negative accumulator value saturates to 2^(ACCW-1)-1.
- Config writes during ACCUM take effect from the next ACCUM.
  - Coefficient/len writes mid-correlation may corrupt only that one result.
- Synchronous reset in any state returns to IDLE next cycle; a pending sample is discarded.

Optional Feature:
MATCH_FILTER_SAT_EN
- Defined: ACCUM additions saturate at ±(2^(ACCW-1)-1); an extra sticky bit sat_seen is ORed into overrun.
- Undefined: two's-complement wrap; overrun reflects sample drops only.

Test Plan:
- Coefficients all 00, len=8, threshold=799; eight strobes of (100,0) spaced 20 cycles -> eighth valid: mag=800, match=1; earlier valids: mag=100..700, match=0.
- Coefficient 0=01, len=1; sample (0,50) -> accumulator (-50,0); mag=50 at exactly cycle 3 after shift (N=1).
- Accumulator (300,-400) via len=2, taps (300,0),(0,-400), coefficients 00 -> mag=400+150=550.
- Threshold=0, holdoff=3, constant nonzero input -> match pattern 1,0,0,0,1 over five valids.
- Three rxstrobes on consecutive cycles, len=64 -> overrun=1, exactly two valids produced (first and last sample), overrun stays 1 until reset.
- Reset asserted during ACCUM -> next cycle: valid=0, mag=0, FSM IDLE; next strobe after reset processes with len=TAPS, coefficients 00.

Source files
------------

// File: rtl/match_filter_param.sv
// match_filter_param: parametrised +-1/+-j complex correlator with magnitude threshold, match holdoff and overrun flag.
// Optional build macro MATCH_FILTER_SAT_EN: saturating accumulation, with saturation events ORed into overrun.
module match_filter_param #(
    parameter int DW   = 16,
    parameter int TAPS = 64,
    parameter int PAR  = 8,
    parameter int ACCW = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     r_input,
    input  logic [15:0]     i_input,
    input  logic            rxstrobe,
    input  logic [31:0]     cdata,
    input  logic [7:0]      caddr,
    input  logic            cwrite,
    output logic            valid,
    output logic            match,
    output logic [ACCW-1:0] mag,
    output logic            overrun
);
    localparam int TI = $clog2(TAPS);
    localparam int LW = TI + 1;
    localparam int NB = TAPS / PAR;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    // one beat sums PAR taps; the extra bits keep acc + beat_sum exact before wrap/saturate
    localparam int SW = ACCW + $clog2(PAR) + 1;
    localparam logic signed [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MNEG = {1'b1, {(ACCW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, MAG, CMP} state_t;

    state_t state, nxt;

    logic signed [DW-1:0]   dl_r [TAPS];
    logic signed [DW-1:0]   dl_i [TAPS];
    logic [1:0]             coef [TAPS];
    logic signed [DW-1:0]   pend_r, pend_i;
    logic                   pend_full, drop;
    logic [ACCW-1:0]        thresh;
    logic [LW-1:0]          len;
    logic [15:0]            holdoff, hold_cnt;
    logic signed [ACCW-1:0] acc_r, acc_i, nxt_r, nxt_i;
    logic [BW-1:0]          beat;
    logic signed [SW-1:0]   tr [PAR];
    logic signed [SW-1:0]   ti [PAR];
    logic signed [SW-1:0]   sum_r, sum_i, wide_r, wide_i;
    logic [ACCW-1:0]        abs_r, abs_i, mx, mn;
    logic                   last;

    function automatic logic signed [ACCW-1:0] fit(input logic signed [SW-1:0] v);
`ifdef MATCH_FILTER_SAT_EN
        return v > SW'(SMAX) ? SMAX : v < -SW'(SMAX) ? -SMAX : ACCW'(v);
`else
        return ACCW'(v);
`endif
    endfunction

    // the most negative value has no positive twin, so it clips to the largest positive one
    function automatic logic [ACCW-1:0] abs_sat(input logic signed [ACCW-1:0] v);
        return v == MNEG ? ACCW'(SMAX) : v < 0 ? ACCW'(-v) : ACCW'(v);
    endfunction

    // tap p of the current beat, rotated by its coefficient and masked beyond len
    for (genvar p = 0; p < PAR; p++) begin : g_tap
        logic [TI-1:0]        idx;
        logic signed [SW-1:0] xr, xi;
        logic [1:0]           c;
        logic                 off;
        assign idx   = TI'(32'(beat) * PAR + p);
        assign xr    = SW'(dl_r[idx]);
        assign xi    = SW'(dl_i[idx]);
        assign c     = coef[idx];
        assign off   = {1'b0, idx} >= len;
        assign tr[p] = off ? '0 : c == 2'd0 ? xr : c == 2'd1 ? -xi : c == 2'd2 ? xi : -xr;
        assign ti[p] = off ? '0 : c == 2'd0 ? xi : c == 2'd1 ? xr : c == 2'd2 ? -xr : -xi;
    end

    // adder tree over the PAR taps of one beat
    always_comb begin
        sum_r = '0;
        sum_i = '0;
        for (int k = 0; k < PAR; k++) begin
            sum_r = sum_r + tr[k];
            sum_i = sum_i + ti[k];
        end
    end

    assign wide_r = SW'(acc_r) + sum_r;
    assign wide_i = SW'(acc_i) + sum_i;
    assign nxt_r  = fit(wide_r);
    assign nxt_i  = fit(wide_i);
    assign last   = (32'(beat) + 32'd1) * 32'(PAR) >= 32'(len);
    assign abs_r  = abs_sat(acc_r);
    assign abs_i  = abs_sat(acc_i);
    assign mx     = abs_r > abs_i ? abs_r : abs_i;
    assign mn     = abs_r > abs_i ? abs_i : abs_r;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // next state and the one-cycle valid/match pulse
    always_comb begin
        nxt   = state;
        valid = 1'b0;
        match = 1'b0;
        case (state)
            IDLE:  nxt = pend_full ? ACCUM : IDLE;
            ACCUM: nxt = last ? MAG : ACCUM;
            MAG:   nxt = CMP;
            CMP: begin
                nxt   = IDLE;
                valid = 1'b1;
                match = mag > thresh && hold_cnt == '0;
            end
            default: nxt = IDLE;
        endcase
    end

    // one-deep sample intake; a strobe onto a full slot overwrites it and flags the drop
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_full <= 1'b0;
            pend_r    <= '0;
            pend_i    <= '0;
            drop      <= 1'b0;
        end else begin
            pend_full <= rxstrobe | (pend_full & (state != IDLE));
            drop      <= drop | (rxstrobe & pend_full);
            if (rxstrobe) begin
                pend_r <= r_input[DW-1:0];
                pend_i <= i_input[DW-1:0];
            end
        end
    end

    // delay line advances only when a pending sample starts a correlation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (state == IDLE && pend_full) begin
            dl_r[0] <= pend_r;
            dl_i[0] <= pend_i;
            for (int k = 1; k < TAPS; k++) begin
                dl_r[k] <= dl_r[k-1];
                dl_i[k] <= dl_i[k-1];
            end
        end
    end

    // configuration registers, written on the cycle after cwrite
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh  <= '0;
            len     <= LW'(TAPS);
            holdoff <= '0;
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
        end else if (cwrite) begin
            if (caddr == 8'd0) thresh <= cdata[ACCW-1:0];
            if (caddr == 8'd1) begin
                len     <= (cdata[7:0] == 8'd0 || 32'(cdata[7:0]) > TAPS) ? LW'(TAPS) : LW'(cdata[7:0]);
                holdoff <= cdata[31:16];
            end
            for (int k = 0; k < TAPS; k++)
                if (32'(caddr) == 2 + k / 16) coef[k] <= cdata[2 * (k % 16) +: 2];
        end
    end

    // accumulation, magnitude estimate and match holdoff
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= '0;
            acc_i    <= '0;
            beat     <= '0;
            mag      <= '0;
            hold_cnt <= '0;
        end else begin
            acc_r <= state == ACCUM ? nxt_r : state == IDLE ? '0 : acc_r;
            acc_i <= state == ACCUM ? nxt_i : state == IDLE ? '0 : acc_i;
            beat  <= state == ACCUM ? beat + 1'b1 : '0;
            if (state == MAG) mag <= mx + (mn >> 1);
            if (state == CMP) hold_cnt <= hold_cnt != '0 ? hold_cnt - 16'd1 : match ? holdoff : hold_cnt;
        end
    end

`ifdef MATCH_FILTER_SAT_EN
    logic sat_seen;

    // sticky record of any clipped accumulation
    always_ff @(posedge clk) begin
        if (reset)
            sat_seen <= 1'b0;
        else if (state == ACCUM && (SW'(nxt_r) != wide_r || SW'(nxt_i) != wide_i))
            sat_seen <= 1'b1;
    end

    assign overrun = drop | sat_seen;
`else
    assign overrun = drop;
`endif
endmodule

// File: tb/tb_match_filter_param.sv
// tb_match_filter_param: randomized and directed bench comparing match_filter_param against a transaction-level correlator model.
module tb_match_filter_param;
    localparam int ACCW = 24;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     r_input = '0;
    logic [15:0]     i_input = '0;
    logic            rxstrobe = 1'b0;
    logic [31:0]     cdata = '0;
    logic [7:0]      caddr = '0;
    logic            cwrite = 1'b0;
    logic            valid, match, overrun;
    logic [ACCW-1:0] mag;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    match_filter_param dut (
        .clk(clk), .reset(reset), .r_input(r_input), .i_input(i_input),
        .rxstrobe(rxstrobe), .cdata(cdata), .caddr(caddr), .cwrite(cwrite),
        .valid(valid), .match(match), .mag(mag), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // model state: sample history (index 0 newest), config, pending slot, scheduled result
    int hr[64], hi[64], mcoef[64];
    int m_thr, m_len, m_hold, m_hcnt, m_pr, m_pi, m_mag, exp_mag;
    bit m_pf, m_drop, m_valid, m_match, take;
    int cyc = 0, due = -1, free_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // correlation as a sum of samples times unit complex coefficients 1, j, -j, -1
    function automatic int corr_mag();
        int re = 0, im = 0, ur, ui, a, b;
        for (int k = 0; k < m_len; k++) begin
            ur = mcoef[k] == 0 ? 1 : mcoef[k] == 3 ? -1 : 0;
            ui = mcoef[k] == 1 ? 1 : mcoef[k] == 2 ? -1 : 0;
            re += hr[k] * ur - hi[k] * ui;
            im += hr[k] * ui + hi[k] * ur;
        end
        a = re < 0 ? -re : re;
        b = im < 0 ? -im : im;
        return (a > b ? a : b) + (a > b ? b : a) / 2;
    endfunction

    // model advances on each clock edge; a sample takes ceil(len/8)+3 cycles of engine time
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            for (int k = 0; k < 64; k++) begin
                hr[k] = 0;
                hi[k] = 0;
                mcoef[k] = 0;
            end
            m_thr = 0; m_len = 64; m_hold = 0; m_hcnt = 0;
            m_pf = 0; m_drop = 0; m_valid = 0; m_match = 0; m_mag = 0;
            due = -1; free_at = 0;
        end else begin
            m_valid = (cyc == due);
            if (m_valid) begin
                m_mag = exp_mag;
                m_match = exp_mag > m_thr && m_hcnt == 0;
                m_hcnt = m_hcnt > 0 ? m_hcnt - 1 : m_match ? m_hold : 0;
            end
            take = m_pf && cyc >= free_at;
            if (take) begin
                for (int k = 63; k > 0; k--) begin
                    hr[k] = hr[k-1];
                    hi[k] = hi[k-1];
                end
                hr[0] = m_pr;
                hi[0] = m_pi;
                exp_mag = corr_mag();
                due = cyc + (m_len + 7) / 8 + 1;
                free_at = cyc + (m_len + 7) / 8 + 3;
            end
            if (rxstrobe) begin
                m_drop = m_drop | m_pf;
                m_pr = int'($signed(r_input));
                m_pi = int'($signed(i_input));
            end
            m_pf = rxstrobe || (m_pf && !take);
            if (cwrite) begin
                if (caddr == 0) m_thr = int'(cdata[23:0]);
                if (caddr == 1) begin
                    m_len = (cdata[7:0] == 0 || cdata[7:0] > 64) ? 64 : int'(cdata[7:0]);
                    m_hold = int'(cdata[31:16]);
                end
                if (caddr >= 2 && caddr <= 5)
                    for (int m = 0; m < 16; m++) mcoef[(caddr - 2) * 16 + m] = int'((cdata >> (2 * m)) & 3);
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", valid, m_valid);
            chk("overrun", overrun, m_drop);
            chk("mag", mag, m_mag);
            if (m_valid) chk("match", match, m_match);
        end
    end

    task automatic cfg(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        cwrite = 1; caddr = 8'(a); cdata = d;
        @(posedge clk); #1;
        cwrite = 0;
    endtask

    task automatic strobe(input int r, input int i);
        @(posedge clk); #1;
        rxstrobe = 1; r_input = 16'(r); i_input = 16'(i);
        @(posedge clk); #1;
        rxstrobe = 0;
    endtask

    task automatic wait_valid(output logic [ACCW-1:0] mg, output logic mt);
        int n = 0;
        @(negedge clk);
        while (valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", valid, 1);
        mg = mag;
        mt = match;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(!m_pf && cyc >= free_at && cyc > due) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", n < 400, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    initial begin
        logic [ACCW-1:0] mg;
        logic mt;
        int nv;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_match", match, 0);
        chk("rst_mag", mag, 0);
        chk("rst_overrun", overrun, 0);

        // growing sum of identical samples crosses 799 on the eighth
        cfg(1, 8);
        cfg(0, 799);
        for (int n = 1; n <= 8; n++) begin
            strobe(100, 0);
            wait_valid(mg, mt);
            chk("t1_mag", mg, 100 * n);
            chk("t1_match", mt, n == 8);
            repeat (12) @(posedge clk);
        end

        // coefficient j on (0,50), single tap: result three cycles after the shift
        cfg(2, 1);
        cfg(1, 1);
        strobe(0, 50);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t2_latency", valid, j == 3);
        end
        chk("t2_mag", mag, 50);
        repeat (3) @(posedge clk);

        // (300,-400) gives 400 + 150
        cfg(2, 0);
        cfg(1, 2);
        strobe(0, -400);
        wait_valid(mg, mt);
        strobe(300, 0);
        wait_valid(mg, mt);
        chk("t3_mag", mg, 550);
        repeat (3) @(posedge clk);

        // holdoff 3 with threshold 0
        cfg(0, 0);
        cfg(1, (3 << 16) | 4);
        for (int n = 0; n < 5; n++) begin
            strobe(10, 10);
            wait_valid(mg, mt);
            chk("t4_match", mt, n == 0 || n == 4);
            repeat (3) @(posedge clk);
        end

        // three back-to-back strobes at full length
        cfg(1, 0);
        @(posedge clk); #1 rxstrobe = 1; r_input = 7; i_input = 0;
        @(posedge clk); #1 r_input = 8;
        @(posedge clk); #1 r_input = 9;
        @(posedge clk); #1 rxstrobe = 0;
        nv = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        chk("t5_valids", nv, 2);
        chk("t5_overrun", overrun, 1);
        repeat (20) @(posedge clk);
        chk("t5_sticky", overrun, 1);

        // reset in the middle of accumulation
        strobe(1, 1);
        @(posedge clk);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t6_valid", valid, 0);
        chk("t6_mag", mag, 0);
        chk("t6_overrun", overrun, 0);
        strobe(5, 7);
        wait_valid(mg, mt);
        chk("t6_post_mag", mg, 9);
        chk("t6_post_match", mt, 1);

        // randomized configuration and traffic
        for (int round = 0; round < 25; round++) begin
            wait_idle();
            if (round % 8 == 7) pulse_reset();
            cfg(0, $urandom_range(0, 150000));
            cfg(1, ($urandom_range(0, 3) << 16) | $urandom_range(0, 80));
            for (int a = 2; a < 6; a++)
                if ($urandom_range(0, 1) == 1) cfg(a, $urandom);
            cfg($urandom_range(6, 255), $urandom);
            repeat (60) begin
                @(posedge clk); #1;
                rxstrobe = ($urandom_range(0, 9) == 0);
                r_input = 16'($urandom);
                i_input = 16'($urandom);
            end
            @(posedge clk); #1 rxstrobe = 0;
        end
        wait_idle();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
